// File: rtl/rf_write_arbiter_pkg.sv
// Shared widths and write-port FSM encoding for the register-file write arbiter.
package rf_write_arbiter_pkg;

  localparam int unsigned REG_W = 32;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned NREG  = 32;

  typedef enum logic {
    StIdle  = 1'b0,
    StWrite = 1'b1
  } wr_state_e;

  // Register 0 is hardwired, so index 0 never reserves, clears or stalls.
  function automatic logic idx_nz(input logic [IDX_W-1:0] idx);
    return idx != '0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write bitmap: set on reservation, cleared on writeback transfer, plus operand hazard check.
module rf_scoreboard
  import rf_write_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             set_valid_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic             clr_valid_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic [IDX_W-1:0] chk_ra_i,
  input  logic [IDX_W-1:0] chk_rb_i,
  input  logic [IDX_W-1:0] chk_rd_i,
  output logic [NREG-1:0]  busy_o,
  output logic             stall_o
);

  logic [NREG-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-edge reservation wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid_i && idx_nz(clr_idx_i)) begin
      busy_d[clr_idx_i] = 1'b0;
    end
    if (set_valid_i && idx_nz(set_idx_i)) begin
      busy_d[set_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    stall_o = (busy_q[chk_ra_i] && idx_nz(chk_ra_i)) ||
              (busy_q[chk_rb_i] && idx_nz(chk_rb_i)) ||
              (busy_q[chk_rd_i] && idx_nz(chk_rd_i));
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates ALU and MEM writebacks onto a single register-file write port, one cycle after accept.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [IDX_W-1:0] alu_rd,
  input  logic [REG_W-1:0] alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [IDX_W-1:0] mem_rd,
  input  logic [REG_W-1:0] mem_data,
  input  logic             rsv_valid,
  input  logic [IDX_W-1:0] rsv_rd,
  input  logic [IDX_W-1:0] chk_ra,
  input  logic [IDX_W-1:0] chk_rb,
  input  logic [IDX_W-1:0] chk_rd,
  output logic             chk_stall,
  output logic             rf_le,
  output logic [IDX_W-1:0] rf_rw,
  output logic [REG_W-1:0] rf_pw,
  output logic [NREG-1:0]  busy
);

  wr_state_e        state_q, state_d;
  logic             ptr_q, ptr_d;  // 0: ALU wins next contention, 1: MEM wins
  logic [IDX_W-1:0] rw_q, rw_d;
  logic [REG_W-1:0] pw_q, pw_d;
  logic             alu_gnt, mem_gnt, xfer;
  logic [IDX_W-1:0] sel_rd;
  logic [REG_W-1:0] sel_data;

  // Grants are gated by reset so no output toggles while reset_n is low.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (reset_n) begin
      if (alu_valid && mem_valid) begin
        if (RR_EN && ptr_q) begin
          mem_gnt = 1'b1;
        end else begin
          alu_gnt = 1'b1;
        end
      end else begin
        alu_gnt = alu_valid;
        mem_gnt = mem_valid;
      end
    end
  end

  assign alu_ready = alu_gnt;
  assign mem_ready = mem_gnt;
  assign xfer      = alu_gnt || mem_gnt;
  assign sel_rd    = mem_gnt ? mem_rd   : alu_rd;
  assign sel_data  = mem_gnt ? mem_data : alu_data;

  always_comb begin
    ptr_d   = ptr_q;
    state_d = StIdle;
    rw_d    = rw_q;
    pw_d    = pw_q;
    if (xfer) begin
      ptr_d = alu_gnt;
    end
    if (xfer && idx_nz(sel_rd)) begin
      state_d = StWrite;
      rw_d    = sel_rd;
      pw_d    = sel_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      rw_q    <= '0;
      pw_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rw_q    <= rw_d;
      pw_q    <= pw_d;
    end
  end

  assign rf_le = (state_q == StWrite);
  assign rf_rw = rw_q;
  assign rf_pw = pw_q;

  rf_scoreboard u_scoreboard (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .set_valid_i (rsv_valid),
    .set_idx_i   (rsv_rd),
    .clr_valid_i (xfer),
    .clr_idx_i   (sel_rd),
    .chk_ra_i    (chk_ra),
    .chk_rb_i    (chk_rb),
    .chk_rd_i    (chk_rd),
    .busy_o      (busy),
    .stall_o     (chk_stall)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: round-robin and fixed-priority instances share stimulus.
module tb_rf_write_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        alu_valid, mem_valid, rsv_valid;
  logic [4:0]  alu_rd, mem_rd, rsv_rd, chk_ra, chk_rb, chk_rd;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, chk_stall, rf_le;
  logic [4:0]  rf_rw;
  logic [31:0] rf_pw, busy;
  logic        fp_alu_ready, fp_mem_ready, fp_chk_stall, fp_rf_le;
  logic [4:0]  fp_rf_rw;
  logic [31:0] fp_rf_pw, fp_busy;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got;
  logic [31:0] exp_busy;
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  rf_write_arbiter #(.RR_EN(1'b1)) u_dut (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .chk_rd(chk_rd), .chk_stall(chk_stall),
    .rf_le(rf_le), .rf_rw(rf_rw), .rf_pw(rf_pw), .busy(busy)
  );

  rf_write_arbiter #(.RR_EN(1'b0)) u_fp (
    .clock(clock), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(fp_alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(fp_mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .chk_rd(chk_rd), .chk_stall(fp_chk_stall),
    .rf_le(fp_rf_le), .rf_rw(fp_rf_rw), .rf_pw(fp_rf_pw), .busy(fp_busy)
  );

  task automatic idle_inputs();
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    rsv_valid = 1'b0; rsv_rd = '0;
    chk_ra = '0; chk_rb = '0; chk_rd = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    alu_valid = 1'b1; mem_valid = 1'b1;
    reset_n = 1'b0;
    #3;
    checks++;
    if (rf_le !== 1'b0 || rf_rw !== 5'd0 || rf_pw !== 32'd0 || busy !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: le=%b rw=%0d pw=%h busy=%h, want 0", rf_le, rf_rw, rf_pw, busy);
    end
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || chk_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: alu=%b mem=%b stall=%b, want 0", alu_ready, mem_ready, chk_stall);
    end
    step();
    step();
    idle_inputs();
    #2;
    reset_n = 1'b1;
    exp_busy = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] alu_pat;
    alu_pat = 3'b101;  // bit i: ALU granted on cycle i
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (alu_ready !== alu_pat[i] || mem_ready !== !alu_pat[i]) begin
        errors++;
        $display("FAIL rr_grant[%0d]: alu=%b mem=%b, want alu=%b mem=%b",
                 i, alu_ready, mem_ready, alu_pat[i], !alu_pat[i]);
      end
      exp_q.push_back(alu_pat[i] ? wr_t'{5'd3, 32'hA} : wr_t'{5'd4, 32'hB});
      step();
      got = exp_q.pop_front();
      checks++;
      if (rf_le !== 1'b1 || rf_rw !== got.rd || rf_pw !== got.data) begin
        errors++;
        $display("FAIL rr_write[%0d]: le=%b rw=%0d pw=%h, want le=1 rw=%0d pw=%h",
                 i, rf_le, rf_rw, rf_pw, got.rd, got.data);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (rf_le !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: le=%b, want 0", rf_le);
    end
  endtask

  task automatic test_fixed_priority();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'hB;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fp_alu_ready !== 1'b1 || fp_mem_ready !== 1'b0) begin
        errors++;
        $display("FAIL fp_grant[%0d]: alu=%b mem=%b, want alu=1 mem=0", i, fp_alu_ready, fp_mem_ready);
      end
      step();
      checks++;
      if (fp_rf_le !== 1'b1 || fp_rf_rw !== 5'd3 || fp_rf_pw !== 32'hA) begin
        errors++;
        $display("FAIL fp_write[%0d]: le=%b rw=%0d pw=%h, want le=1 rw=3 pw=a",
                 i, fp_rf_le, fp_rf_rw, fp_rf_pw);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_scoreboard();
    rsv_valid = 1'b1; rsv_rd = 5'd5;
    step();
    exp_busy[5] = 1'b1;
    rsv_valid = 1'b0; chk_ra = 5'd5;
    #1;
    checks++;
    if (busy !== exp_busy || chk_stall !== 1'b1) begin
      errors++;
      $display("FAIL sb_reserve: busy=%h stall=%b, want busy=%h stall=1", busy, chk_stall, exp_busy);
    end
    chk_ra = '0;
    for (int p = 0; p < 2; p++) begin
      chk_rb = (p == 0) ? 5'd5 : 5'd0;
      chk_rd = (p == 1) ? 5'd5 : 5'd0;
      #1;
      checks++;
      if (chk_stall !== 1'b1) begin
        errors++;
        $display("FAIL sb_operand[%0d]: stall=%b, want 1", p, chk_stall);
      end
    end
    chk_ra = 5'd5; chk_rb = 5'd6; chk_rd = '0;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h14;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL sb_alu_ready: ready=%b, want 1", alu_ready);
    end
    exp_q.push_back(wr_t'{5'd5, 32'h14});
    step();
    exp_busy[5] = 1'b0;
    alu_valid = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (busy !== exp_busy || chk_stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_clear: busy=%h stall=%b, want busy=%h stall=0", busy, chk_stall, exp_busy);
    end
    checks++;
    if (rf_le !== 1'b1 || rf_rw !== got.rd || rf_pw !== got.data) begin
      errors++;
      $display("FAIL sb_write: le=%b rw=%0d pw=%h, want le=1 rw=%0d pw=%h",
               rf_le, rf_rw, rf_pw, got.rd, got.data);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_collision();
    rsv_valid = 1'b1; rsv_rd = 5'd7;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
    #1;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL col_ready: ready=%b, want 1", mem_ready);
    end
    exp_q.push_back(wr_t'{5'd7, 32'h77});
    step();
    exp_busy[7] = 1'b1;
    mem_valid = 1'b0;
    got = exp_q.pop_front();
    checks++;
    if (busy !== exp_busy || rf_le !== 1'b1 || rf_rw !== got.rd) begin
      errors++;
      $display("FAIL col_set_wins: busy=%h le=%b rw=%0d, want busy=%h le=1 rw=%0d",
               busy, rf_le, rf_rw, exp_busy, got.rd);
    end
    // Re-reserve an already-busy register; a single write must still clear it.
    step();
    rsv_valid = 1'b0;
    mem_valid = 1'b1; mem_data = 32'h78;
    step();
    exp_busy[7] = 1'b0;
    mem_valid = 1'b0;
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL col_no_count: busy=%h, want %h", busy, exp_busy);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reg0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    rsv_valid = 1'b1; rsv_rd = 5'd0;
    #1;
    checks++;
    if (alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_ready: ready=%b, want 1", alu_ready);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (rf_le !== 1'b0 || busy !== exp_busy || chk_stall !== 1'b0) begin
      errors++;
      $display("FAIL r0_ignored: le=%b busy=%h stall=%b, want le=0 busy=%h stall=0",
               rf_le, busy, chk_stall, exp_busy);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      rsv_valid = 1'b1; rsv_rd = 5'(10 + i);
      step();
      exp_busy[10 + i] = 1'b1;
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = $urandom;
      alu_valid = (i % 2 == 0); alu_rd = 5'(10 + i); alu_data = d;
      mem_valid = (i % 2 == 1); mem_rd = 5'(10 + i); mem_data = d;
      #1;
      checks++;
      if (alu_ready !== (i % 2 == 0) || mem_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: alu=%b mem=%b", i, alu_ready, mem_ready);
      end
      exp_q.push_back(wr_t'{5'(10 + i), d});
      step();
      exp_busy[10 + i] = 1'b0;
      got = exp_q.pop_front();
      checks++;
      if (rf_le !== 1'b1 || rf_rw !== got.rd || rf_pw !== got.data || busy !== exp_busy) begin
        errors++;
        $display("FAIL b2b_write[%0d]: le=%b rw=%0d pw=%h busy=%h, want le=1 rw=%0d pw=%h busy=%h",
                 i, rf_le, rf_rw, rf_pw, busy, got.rd, got.data, exp_busy);
      end
    end
    idle_inputs();
    step();
    checks++;
    if (rf_le !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: le=%b, want 0", rf_le);
    end
  endtask

  task automatic test_reset_mid_write();
    for (int i = 4; i < 8; i++) begin
      rsv_valid = 1'b1; rsv_rd = 5'(i);
      step();
      exp_busy[i] = 1'b1;
    end
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
    step();
    checks++;
    if (rf_le !== 1'b1 || busy !== 32'h0000_00F0) begin
      errors++;
      $display("FAIL rst_pre: le=%b busy=%h, want le=1 busy=000000f0", rf_le, busy);
    end
    mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h88;
    #3;
    reset_n = 1'b0;
    exp_busy = '0;
    #1;
    checks++;
    if (rf_le !== 1'b0 || busy !== exp_busy || rf_rw !== 5'd0 || rf_pw !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: le=%b busy=%h rw=%0d pw=%h, want all 0", rf_le, busy, rf_rw, rf_pw);
    end
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: alu=%b mem=%b, want 0", alu_ready, mem_ready);
    end
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_ptr: alu=%b mem=%b, want alu=1 mem=0", alu_ready, mem_ready);
    end
    exp_q.push_back(wr_t'{5'd9, 32'h99});
    step();
    got = exp_q.pop_front();
    checks++;
    if (rf_le !== 1'b1 || rf_rw !== got.rd || rf_pw !== got.data) begin
      errors++;
      $display("FAIL rst_replay: le=%b rw=%0d pw=%h, want le=1 rw=%0d pw=%h",
               rf_le, rf_rw, rf_pw, got.rd, got.data);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    exp_busy = '0;
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_scoreboard();
    test_collision();
    test_reg0();
    test_back_to_back();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 = round-robin between requesters; 0 = fixed priority, ALU over MEM.
REQ-002 Port clock, in, 1: single clock; all state updates on its rising edge.
REQ-003 Port reset_n, in, 1: asynchronous, active-low reset.
REQ-004 Port alu_valid, in, 1: ALU writeback request.
REQ-005 Port alu_ready, out, 1: ALU request granted this cycle.
REQ-006 Port alu_rd, in, 5: ALU destination register index.
REQ-007 Port alu_data, in, 32: ALU write data.
REQ-008 Ports mem_valid (in, 1), mem_ready (out, 1), mem_rd (in, 5), mem_data (in, 32): MEM writeback request; same meanings as the ALU set.
REQ-009 Port rsv_valid, in, 1: issue-stage destination reservation strobe.
REQ-010 Port rsv_rd, in, 5: register index to reserve.
REQ-011 Ports chk_ra, chk_rb, chk_rd, in, 5 each: operand indices to hazard-check.
REQ-012 Port chk_stall, out, 1: at least one checked operand has a pending write.
REQ-013 Ports rf_le (out, 1), rf_rw (out, 5), rf_pw (out, 32): register-file write enable, write address, write data.
REQ-014 Port busy, out, 32: pending-write bitmap; bit i = register i reserved and not yet written.

Function
REQ-015 A transfer occurs on a rising edge when xxx_valid && xxx_ready; a requester SHALL hold valid, rd and data stable until the transfer.
REQ-016 alu_ready and mem_ready are combinational from the valids and the arbitration pointer.
REQ-017 At most one of alu_ready / mem_ready is high in any cycle.
REQ-018 Only one requester valid: that requester is granted in the same cycle.
REQ-019 Both valid, RR_EN=1: grant the requester not granted last; the 1-bit pointer updates on every transfer.
REQ-020 Both valid, RR_EN=0: ALU is always granted.
REQ-021 Write-port FSM has two states:
  - IDLE: rf_le=0.
  - WRITE: rf_le=1, with rf_rw/rf_pw holding the registered rd/data of the transfer.
REQ-022 A transfer with rd!=0 enters WRITE for exactly the next cycle; no transfer returns the FSM to IDLE.
REQ-023 Back-to-back transfers keep the FSM in WRITE on consecutive cycles; no bubble.
REQ-024 Latency: data accepted at edge N is written into the register file at edge N+1.
REQ-025 A transfer with rd=0 is accepted (ready=1), leaves rf_le=0 and does not touch busy.
REQ-026 rsv_valid with rsv_rd!=0 sets busy[rsv_rd] at the edge; rsv_rd=0 is ignored.
REQ-027 A transfer with rd!=0 clears busy[rd] at the transfer edge.
REQ-028 Reservation and transfer to the same register on the same edge: set wins, bit stays 1.
REQ-029 Reserving an already-busy register: bit stays 1; no counting.
REQ-030 chk_stall = OR of busy[chk_ra], busy[chk_rb], busy[chk_rd], each taken as 0 when its index is 0; combinational.
REQ-031 Neither requester valid: both readies 0, pointer unchanged.

Reset
REQ-032 reset_n low immediately forces: rf_le=0, rf_rw=0, rf_pw=0, busy=0, pointer=ALU-next, FSM=IDLE.
REQ-033 Reset asserted mid-WRITE aborts the write; a transfer in flight is lost and the requester SHALL re-present it.
REQ-034 Outputs are 0 while reset_n is low; normal operation resumes on the first rising edge after release.

Structure
REQ-035 Shared package holds REG_W=32, IDX_W=5, NREG=32 and the FSM state encoding.
REQ-036 The scoreboard (busy bitmap, set/clear, chk_stall) is sub-module rf_scoreboard; arbiter and FSM stay in the top.

Verification
REQ-037 Round-robin contention: RR_EN=1, both valid, alu_rd=3/0xA, mem_rd=4/0xB, held stable -> grants alternate ALU, MEM, ALU; rf_rw=3, 4, 3 on consecutive cycles with rf_le continuously 1.
REQ-038 Fixed priority: RR_EN=0, both valid for 3 cycles -> alu_ready=1 every cycle, mem_ready=0.
REQ-039 Scoreboard and stall: rsv 5, then chk_ra=5 -> chk_stall=1; ALU writes rd=5/0x14 -> busy[5]=0 after that edge, chk_stall=0, rf_pw=0x14 the following cycle.
REQ-040 Same-edge collision: rsv_rd=7 and a MEM transfer rd=7 on one edge -> busy[7]=1.
REQ-041 Register 0: ALU transfer rd=0 and rsv_rd=0 -> ready=1, rf_le stays 0, busy=0; chk_ra=0 never stalls.
REQ-042 Reset during WRITE: reset_n low mid-cycle with rf_le=1, busy=0x0000_00F0 -> rf_le=0 and busy=0 immediately, without waiting for a clock edge.
